// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded fields, resolves operand forwarding
// and picks operand B. Define IDEX_FWD_EN to enable EX/MEM and MEM/WB forwarding.
module id_ex_stage #(
  parameter int VAR_WIDTH      = 32,
  parameter int OP_WIDTH       = 4,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OP_WIDTH-1:0]       in_alu_op,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs2_addr,
  input  logic [VAR_WIDTH-1:0]      in_rs1_data,
  input  logic [VAR_WIDTH-1:0]      in_rs2_data,
  input  logic [VAR_WIDTH-1:0]      in_imm,
  input  logic                      in_use_imm,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd_addr,
  input  logic                      in_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic                      exmem_we,
  input  logic                      memwb_we,
  input  logic [VAR_WIDTH-1:0]      exmem_data,
  input  logic [VAR_WIDTH-1:0]      memwb_data,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OP_WIDTH-1:0]       alu_opcode,
  output logic [VAR_WIDTH-1:0]      alu_a,
  output logic [VAR_WIDTH-1:0]      alu_b,
  output logic [VAR_WIDTH-1:0]      out_rs2_data,
  output logic [REG_ADDR_WIDTH-1:0] out_rd_addr,
  output logic                      out_reg_write
);

  logic [VAR_WIDTH-1:0] fwd_rs1, fwd_rs2;
  logic                 accept;

`ifdef IDEX_FWD_EN
  // Nearest producer wins; x0 always reads the regfile value.
  function automatic logic [VAR_WIDTH-1:0] fwd_sel(
    input logic [REG_ADDR_WIDTH-1:0] rs,
    input logic [VAR_WIDTH-1:0]      rf,
    input logic                      em_we,
    input logic [REG_ADDR_WIDTH-1:0] em_rd,
    input logic [VAR_WIDTH-1:0]      em_data,
    input logic                      mw_we,
    input logic [REG_ADDR_WIDTH-1:0] mw_rd,
    input logic [VAR_WIDTH-1:0]      mw_data
  );
    if (rs == '0)                  return rf;
    else if (em_we && em_rd == rs) return em_data;
    else if (mw_we && mw_rd == rs) return mw_data;
    else                           return rf;
  endfunction

  assign fwd_rs1 = fwd_sel(in_rs1_addr, in_rs1_data, exmem_we, exmem_rd, exmem_data,
                           memwb_we, memwb_rd, memwb_data);
  assign fwd_rs2 = fwd_sel(in_rs2_addr, in_rs2_data, exmem_we, exmem_rd, exmem_data,
                           memwb_we, memwb_rd, memwb_data);
`else
  logic unused_fwd;
  assign fwd_rs1    = in_rs1_data;
  assign fwd_rs2    = in_rs2_data;
  assign unused_fwd = ^{in_rs1_addr, in_rs2_addr, exmem_rd, memwb_rd, exmem_we,
                        memwb_we, exmem_data, memwb_data};
`endif

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Flush outranks capture; data fields are left as-is on flush/drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      alu_opcode    <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      out_rs2_data  <= '0;
      out_rd_addr   <= '0;
      out_reg_write <= 1'b0;
    end else if (flush) begin
      out_valid     <= 1'b0;
      out_reg_write <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      alu_opcode    <= in_alu_op;
      alu_a         <= fwd_rs1;
      alu_b         <= in_use_imm ? in_imm : fwd_rs2;
      out_rs2_data  <= fwd_rs2;
      out_rd_addr   <= in_rd_addr;
      out_reg_write <= in_reg_write && (in_rd_addr != '0);
    end else if (out_ready) begin
      out_valid     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: scoreboard of expected ALU-side outputs,
// popped whenever the stage hands an instruction downstream.
module tb_id_ex_stage;
  localparam logic [3:0] ALUADD = 4'd0;
  localparam logic [3:0] ALUSUB = 4'd1;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_use_imm, in_reg_write;
  logic [3:0]  in_alu_op, alu_opcode;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr, exmem_rd, memwb_rd, out_rd_addr;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm, exmem_data, memwb_data;
  logic [31:0] alu_a, alu_b, out_rs2_data;
  logic        exmem_we, memwb_we, flush, out_valid, out_ready, out_reg_write;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_op(in_alu_op), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_rd_addr(in_rd_addr), .in_reg_write(in_reg_write),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd), .exmem_we(exmem_we), .memwb_we(memwb_we),
    .exmem_data(exmem_data), .memwb_data(memwb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .alu_opcode(alu_opcode),
    .alu_a(alu_a), .alu_b(alu_b), .out_rs2_data(out_rs2_data),
    .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                       input logic ui, input logic [4:0] rd, input logic we);
    in_valid = 1'b1; in_alu_op = op; in_rs1_addr = rs1; in_rs2_addr = rs2;
    in_rs1_data = d1; in_rs2_data = d2; in_imm = imm; in_use_imm = ui;
    in_rd_addr = rd; in_reg_write = we;
  endtask

  task automatic push(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] rs2, input logic [4:0] rd, input logic we);
    exp_t e;
    e.op = op; e.a = a; e.b = b; e.rs2 = rs2; e.rd = rd; e.we = we;
    sb.push_back(e);
  endtask

  // Transfer happens on the coming edge when valid && ready are both seen here.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("opcode", 32'(alu_opcode), 32'(e.op));
        check("alu_a", alu_a, e.a);
        check("alu_b", alu_b, e.b);
        check("rs2_data", out_rs2_data, e.rs2);
        check("rd_addr", 32'(out_rd_addr), 32'(e.rd));
        check("reg_write", 32'(out_reg_write), 32'(e.we));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    exmem_we = 1'b1; exmem_rd = 5'd9;  exmem_data = 32'hDEAD_0001;
    memwb_we = 1'b1; memwb_rd = 5'd10; memwb_data = 32'hBEEF_0002;
    drive(ALUADD, 5'd1, 5'd2, 32'h77, 32'h88, 32'h99, 1'b1, 5'd4, 1'b1);

    // reset held two edges with in_valid high
    tick(); tick();
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_op", 32'(alu_opcode), 32'd0);
    check("rst_a", alu_a, 32'd0);
    check("rst_b", alu_b, 32'd0);
    check("rst_rs2", out_rs2_data, 32'd0);
    check("rst_rd", 32'(out_rd_addr), 32'd0);
    check("rst_we", 32'(out_reg_write), 32'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
    @(negedge clk);
    check("post_rst_ready", 32'(in_ready), 32'd1);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    tick();

    // plain ADD with immediate, then a register-register SUB
    drive(ALUADD, 5'd1, 5'd2, 32'h10, 32'h22, 32'h5, 1'b1, 5'd4, 1'b1);
    push(ALUADD, 32'h10, 32'h5, 32'h22, 5'd4, 1'b1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("add_latency_valid", 32'(out_valid), 32'd1);
    tick();
    drive(ALUSUB, 5'd11, 5'd12, 32'd100, 32'd30, 32'h777, 1'b0, 5'd6, 1'b1);
    push(ALUSUB, 32'd100, 32'd30, 32'd30, 5'd6, 1'b1);
    tick();

    // back-to-back forwarding cases (accept and drain on the same edge)
    exmem_rd = 5'd3; exmem_data = 32'hAAAA; memwb_rd = 5'd3; memwb_data = 32'hBBBB;
    drive(ALUADD, 5'd3, 5'd7, 32'h1111, 32'h2222, 32'h5, 1'b1, 5'd8, 1'b1);
`ifdef IDEX_FWD_EN
    push(ALUADD, 32'hAAAA, 32'h5, 32'h2222, 5'd8, 1'b1);
`else
    push(ALUADD, 32'h1111, 32'h5, 32'h2222, 5'd8, 1'b1);
`endif
    tick();
    exmem_rd = 5'd0; memwb_rd = 5'd0;
    drive(ALUADD, 5'd0, 5'd7, 32'h0, 32'h2222, 32'h6, 1'b1, 5'd8, 1'b1);
    push(ALUADD, 32'h0, 32'h6, 32'h2222, 5'd8, 1'b1);
    tick();
    exmem_we = 1'b0; exmem_rd = 5'd3; memwb_rd = 5'd3;
    drive(ALUSUB, 5'd3, 5'd3, 32'h1111, 32'h2222, 32'h7, 1'b0, 5'd9, 1'b1);
`ifdef IDEX_FWD_EN
    push(ALUSUB, 32'hBBBB, 32'hBBBB, 32'hBBBB, 5'd9, 1'b1);
`else
    push(ALUSUB, 32'h1111, 32'h2222, 32'h2222, 5'd9, 1'b1);
`endif
    tick();
    exmem_we = 1'b1; exmem_rd = 5'd5; exmem_data = 32'hCCCC; memwb_we = 1'b0; memwb_rd = 5'd5;
    drive(ALUADD, 5'd2, 5'd5, 32'h3333, 32'h4444, 32'h9, 1'b1, 5'd10, 1'b1);
`ifdef IDEX_FWD_EN
    push(ALUADD, 32'h3333, 32'h9, 32'hCCCC, 5'd10, 1'b1);
`else
    push(ALUADD, 32'h3333, 32'h9, 32'h4444, 5'd10, 1'b1);
`endif
    tick();
    exmem_we = 1'b1; exmem_rd = 5'd9;  exmem_data = 32'hDEAD_0001;
    memwb_we = 1'b1; memwb_rd = 5'd10; memwb_data = 32'hBEEF_0002;
    in_valid = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("drain_valid", 32'(out_valid), 32'd0);
    tick();

    // stall: A held three cycles while B waits at the input
    drive(4'd2, 5'd13, 5'd14, 32'hA1, 32'hA2, 32'h0, 1'b0, 5'd15, 1'b1);
    push(4'd2, 32'hA1, 32'hA2, 32'hA2, 5'd15, 1'b1);
    tick();
    out_ready = 1'b0;
    drive(4'd3, 5'd16, 5'd17, 32'hB1, 32'hB2, 32'h44, 1'b1, 5'd18, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_op", 32'(alu_opcode), 32'd2);
      check("stall_a", alu_a, 32'hA1);
      check("stall_b", alu_b, 32'hA2);
      tick();
    end
    out_ready = 1'b1;
    push(4'd3, 32'hB1, 32'h44, 32'hB2, 5'd18, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();

    // flush while holding, with a new instruction offered
    drive(4'd4, 5'd19, 5'd20, 32'hC1, 32'hC2, 32'h0, 1'b0, 5'd20, 1'b1);
    tick();
    out_ready = 1'b0; flush = 1'b1;
    drive(4'd5, 5'd21, 5'd22, 32'hD1, 32'hD2, 32'h0, 1'b0, 5'd23, 1'b1);
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready), 32'd0);
    check("flush_pre_valid", 32'(out_valid), 32'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_we", 32'(out_reg_write), 32'd0);
    tick();
    @(negedge clk);
    check("flush_dropped", 32'(out_valid), 32'd0);
    tick();

    // rd = x0 never writes
    drive(ALUADD, 5'd21, 5'd22, 32'h55, 32'h66, 32'h1, 1'b1, 5'd0, 1'b1);
    push(ALUADD, 32'h55, 32'h1, 32'h66, 5'd0, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();

    // reset while stalled drops the held instruction
    drive(4'd6, 5'd23, 5'd24, 32'hE1, 32'hE2, 32'h0, 1'b0, 5'd22, 1'b1);
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("rst_stall_valid", 32'(out_valid), 32'd0);
    check("rst_stall_a", alu_a, 32'd0);
    check("rst_stall_rd", 32'(out_rd_addr), 32'd0);
    check("rst_stall_we", 32'(out_reg_write), 32'd0);
    tick();

    @(negedge clk);
    check("sb_leftover", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
